stream_pad_unit: RTL and testbench



---
 rtl/cnn_pad_pkg.sv | 32 +++
 rtl/pad_grid_counter.sv | 67 ++++++
 rtl/stream_pad_unit.sv | 180 ++++++++++++++++++
 tb/tb_stream_pad_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pad_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pad_pkg
//   Shared types and helpers for the streaming border padder.
//   - pad_state_e : frame walker state (IDLE between frames, RUN on the grid)
//   - out_dim     : padded dimension for an input dimension and border width
//   - cnt_w       : counter width able to index 0..n-1 (never below one bit)
//   - is_border   : true when grid position (r,c) lies in the pad ring
// ---------------------------------------------------------------------------
package cnn_pad_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pad_state_e;

    function automatic int out_dim(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    // A one-entry axis still needs a one-bit counter so ports never collapse
    // to zero width.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit is_border(input int r, input int c,
                                     input int oh, input int ow,
                                     input int pad);
        return (r < pad) || (r >= oh - pad) || (c < pad) || (c >= ow - pad);
    endfunction

endpackage : cnn_pad_pkg

// File: rtl/pad_grid_counter.sv
// ---------------------------------------------------------------------------
// pad_grid_counter
//   Raster-order row/column walker over the padded OH x OW output grid.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (counters to 0)
//     clear     : force the walker back to (0,0) (frame start)
//     advance   : step one position; column wraps OW-1 -> 0 and bumps row,
//                 the final position wraps back to (0,0)
//     row, col  : current grid position
//     last      : current position is (OH-1, OW-1)
// ---------------------------------------------------------------------------
module pad_grid_counter
    import cnn_pad_pkg::*;
#(
    parameter int OH = 16,
    parameter int OW = 16,
    parameter int RW = cnt_w(OH),
    parameter int CW = cnt_w(OW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_last;
    logic          col_last;

    assign row_last = (row_q == RW'(OH - 1));
    assign col_last = (col_q == CW'(OW - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_last && col_last;

endmodule : pad_grid_counter

// File: rtl/stream_pad_unit.sv
// ---------------------------------------------------------------------------
// stream_pad_unit
//   Streams an IMG_H x IMG_W raster feature map through and surrounds it with
//   a PAD-pixel ring of a runtime pad value, one output beat per cycle.
//   Build option: define STREAM_PAD_SIDEBAND_EN to add out_sof / out_eol.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     pad_value   : pad pixel, sampled once at each frame start, replicated
//                   over all CH lanes
//     in_valid/in_ready/in_data   : input pixel stream (channel 0 in MSBs)
//     out_valid/out_ready/out_data: padded output stream (one register stage)
//     frame_done  : pulses while the final beat of a frame is accepted
//     out_sof     : (option) beat is grid position (0,0)
//     out_eol     : (option) beat is the last column of a row
// ---------------------------------------------------------------------------
module stream_pad_unit
    import cnn_pad_pkg::*;
#(
    parameter int IMG_H = 14,
    parameter int IMG_W = 14,
    parameter int PAD   = 1,
    parameter int PIX_W = 4,
    parameter int CH    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_W-1:0]      pad_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_W*CH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_W*CH-1:0]   out_data,
    output logic                  frame_done
`ifdef STREAM_PAD_SIDEBAND_EN
    ,
    output logic                  out_sof,
    output logic                  out_eol
`endif
);

    localparam int OH = out_dim(IMG_H, PAD);
    localparam int OW = out_dim(IMG_W, PAD);
    localparam int RW = cnt_w(OH);
    localparam int CW = cnt_w(OW);
    localparam int DW = PIX_W * CH;

    if (PAD < 0 || PAD > 4 || IMG_H < 1 || IMG_W < 1) begin : g_param_check
        $error("stream_pad_unit: PAD must be 0..4 and IMG_H/IMG_W at least 1");
    end

    pad_state_e        state_q, state_d;
    logic [PIX_W-1:0]  pad_q, pad_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              grid_last;
    logic              border;
    logic              may_load;
    logic              load;
    logic              in_ready_c;
    logic [DW-1:0]     load_data;

    // Grid position walker: held at (0,0) while idle, steps on every load.
    pad_grid_counter #(
        .OH (OH),
        .OW (OW),
        .RW (RW),
        .CW (CW)
    ) u_grid (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .advance (load),
        .row     (row),
        .col     (col),
        .last    (grid_last)
    );

    assign border = is_border(int'(row), int'(col), OH, OW, PAD);

    // The single output register can take a new beat when it is empty or its
    // current beat leaves this cycle; that is what gives back-to-back beats.
    assign may_load = !out_valid_q || out_ready;

    always_comb begin
        state_d    = state_q;
        pad_d      = pad_q;
        in_ready_c = 1'b0;
        load       = 1'b0;
        load_data  = in_data;

        case (state_q)
            IDLE: begin
                state_d = RUN;
                pad_d   = pad_value;
            end
            RUN: begin
                if (border) begin
                    load      = may_load;
                    load_data = {CH{pad_q}};
                end else begin
                    in_ready_c = may_load;
                    load       = in_valid && may_load;
                end
                if (load && grid_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            out_last_d  = grid_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Frame state and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pad_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pad_q       <= pad_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef STREAM_PAD_SIDEBAND_EN
    logic out_sof_q, out_sof_d;
    logic out_eol_q, out_eol_d;

    always_comb begin
        out_sof_d = out_sof_q;
        out_eol_d = out_eol_q;
        if (load) begin
            out_sof_d = (row == '0) && (col == '0);
            out_eol_d = (col == CW'(OW - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sof_q <= 1'b0;
            out_eol_q <= 1'b0;
        end else begin
            out_sof_q <= out_sof_d;
            out_eol_q <= out_eol_d;
        end
    end

    assign out_sof = out_sof_q;
    assign out_eol = out_eol_q;
`endif

    // An upstream beat must not count as accepted while reset is applied.
    assign in_ready   = in_ready_c && !rst;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = out_valid_q && out_ready && out_last_q;

endmodule : stream_pad_unit

// File: tb/tb_stream_pad_unit.sv
`timescale 1ns/1ps
module tb_stream_pad_unit;

    localparam int NCFG    = 4;
    localparam int CFG_H  [NCFG] = '{2, 14, 3, 3};
    localparam int CFG_W  [NCFG] = '{2, 14, 3, 2};
    localparam int CFG_P  [NCFG] = '{1, 1, 0, 2};
    localparam int CFG_PW [NCFG] = '{4, 4, 8, 4};
    localparam int CFG_CH [NCFG] = '{1, 1, 2, 3};
    localparam int NF      = 5;
    localparam int ABORT_F = 2;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic chk(input int cfg, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL cfg%0d %s: got %h, expected %h at %0t", cfg, name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int H    = CFG_H[g];
        localparam int W    = CFG_W[g];
        localparam int P    = CFG_P[g];
        localparam int PW   = CFG_PW[g];
        localparam int C    = CFG_CH[g];
        localparam int DW   = PW * C;
        localparam int OH   = H + 2 * P;
        localparam int OW   = W + 2 * P;
        localparam logic [31:0] DMASK = (32'd1 << DW) - 32'd1;
        localparam logic [31:0] PMASK = (32'd1 << PW) - 32'd1;

        logic           rst;
        logic [PW-1:0]  pad_value;
        logic           in_valid;
        logic           in_ready;
        logic [DW-1:0]  in_data;
        logic           out_valid;
        logic           out_ready;
        logic [DW-1:0]  out_data;
        logic           frame_done;

        beat_t          exp_q[$];
        logic [31:0]    ins [H*W];
        int             frames_done    = 0;
        int             beats_in_frame = 0;
        int             cur_f          = 0;
        int             ph             = 0;
        bit             all_pushed     = 1'b0;
        bit             fin            = 1'b0;

        stream_pad_unit #(
            .IMG_H (H),
            .IMG_W (W),
            .PAD   (P),
            .PIX_W (PW),
            .CH    (C)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .pad_value  (pad_value),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_data    (in_data),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_data   (out_data),
            .frame_done (frame_done)
        );

        function automatic logic [31:0] rep_pad(input logic [31:0] p);
            logic [31:0] d = '0;
            for (int k = 0; k < C; k++) d = (d << PW) | (p & PMASK);
            return d;
        endfunction

        // Frame inputs: fixed patterns for the first frames of the 2x2 and
        // 14x14 cases, random data elsewhere.
        task automatic fill_ins(input int f);
            for (int k = 0; k < H * W; k++) begin
                if (g == 0 && f < 2)      ins[k] = k + 2;
                else if (g == 1 && f == 0) ins[k] = k % 16;
                else                       ins[k] = $urandom & DMASK;
            end
        endtask

        // Reference: the padded picture is the input image placed at offset
        // (P,P) inside an OH x OW canvas filled with the pad pixel.
        task automatic push_frame(input logic [31:0] p);
            beat_t b;
            for (int r = 0; r < OH; r++) begin
                for (int c = 0; c < OW; c++) begin
                    if (r < P || r >= P + H || c < P || c >= P + W) b.d = rep_pad(p);
                    else b.d = ins[(r - P) * W + (c - P)];
                    b.last = (r == OH - 1) && (c == OW - 1);
                    exp_q.push_back(b);
                end
            end
        endtask

        // Downstream ready: always on, then 1,0,0,1 repeating, then random.
        initial begin
            out_ready = 1'b1;
            forever begin
                @(posedge clk); #1;
                case (cur_f % 3)
                    0: out_ready = 1'b1;
                    1: begin
                        out_ready = (ph == 0) || (ph == 3);
                        ph = (ph + 1) % 4;
                    end
                    default: out_ready = ($urandom_range(0, 2) != 0);
                endcase
            end
        end

        // Stimulus driver
        initial begin
            int          idx;
            bit          aborted;
            logic [31:0] pad_cur;
            aborted  = 1'b0;
            rst      = 1'b1;
            in_valid = 1'b0;
            in_data  = '0;
            pad_cur  = (g == 0) ? 32'd1 : (g == 1) ? 32'd0 : ($urandom & PMASK);
            pad_value = PW'(pad_cur);
            fill_ins(0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            chk(g, "reset_out_valid", 32'(out_valid), 32'd0);
            chk(g, "reset_out_data", 32'(out_data), 32'd0);
            chk(g, "reset_in_ready", 32'(in_ready), 32'd0);
            chk(g, "reset_frame_done", 32'(frame_done), 32'd0);
            push_frame(pad_cur);

            for (int f = 0; f < NF; f++) begin
                cur_f = f;
                idx   = 0;
                while (idx < H * W) begin
                    @(posedge clk); #1;
                    if (f == ABORT_F && !aborted && frames_done == f && beats_in_frame >= 5) begin
                        aborted  = 1'b1;
                        in_valid = 1'b0;
                        rst      = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        chk(g, "abort_out_valid", 32'(out_valid), 32'd0);
                        chk(g, "abort_frame_done", 32'(frame_done), 32'd0);
                        pad_cur = 32'(pad_value);
                        push_frame(pad_cur);
                        idx = 0;
                    end
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data  = DW'(ins[idx]);
                    @(negedge clk);
                    if (in_valid && in_ready) begin
                        idx++;
                        if (idx == 1) begin
                            if (g == 0 && f == 0)      pad_value = PW'(1);
                            else if (g == 0 && f == 1) pad_value = PW'(7);
                            else                       pad_value = PW'($urandom & PMASK);
                        end
                    end
                end
                if (f < NF - 1) begin
                    fill_ins(f + 1);
                    pad_cur = 32'(pad_value);
                    push_frame(pad_cur);
                end
            end
            all_pushed = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        // Monitor / scoreboard
        initial begin
            beat_t         b;
            bit            prev_stall;
            logic [DW-1:0] prev_data;
            prev_stall = 1'b0;
            prev_data  = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    exp_q.delete();
                    beats_in_frame = 0;
                    prev_stall     = 1'b0;
                end else if (!fin) begin
                    if (prev_stall) begin
                        chk(g, "stall_valid", 32'(out_valid), 32'd1);
                        chk(g, "stall_data", 32'(out_data), 32'(prev_data));
                    end
                    if (in_ready) begin
                        chk(g, "in_ready_under_stall", 32'(out_valid && !out_ready), 32'd0);
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL cfg%0d unexpected_beat: got %h, expected no beat at %0t",
                                     g, out_data, $time);
                        end else begin
                            b = exp_q.pop_front();
                            chk(g, "out_data", 32'(out_data), b.d);
                            chk(g, "frame_done", 32'(frame_done), 32'(b.last));
                            beats_in_frame++;
                            if (b.last) begin
                                frames_done++;
                                beats_in_frame = 0;
                                if (all_pushed && exp_q.size() == 0) begin
                                    fin = 1'b1;
                                    n_done++;
                                end
                            end
                        end
                    end else begin
                        chk(g, "frame_done_quiet", 32'(frame_done), 32'd0);
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_data  = out_data;
                end
            end
        end
    end

    initial begin
        wait (n_done == NCFG);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got %0d of %0d configurations finished, expected all", n_done, NCFG);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_stream_pad_unit
